// File: rtl/cmul_scheduler.sv
// Complex multiply (ar + j*ai)*(br + j*bi) over one shared Q-format real multiplier.
// Optional build macro CMUL_SAT_EN: saturating ADD stage plus o_sat flag (default: wrap).
`timescale 1ns/1ps
module cmul_scheduler #(
    parameter int N       = 16,
    parameter int Q       = 8,
    parameter int MUL_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_ar,
    input  logic [N-1:0] i_ai,
    input  logic [N-1:0] i_br,
    input  logic [N-1:0] i_bi,
    output logic [N-1:0] o_mul_a,
    output logic [N-1:0] o_mul_b,
    input  logic [N-1:0] i_mul_p,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_re,
    output logic [N-1:0] o_im,
    output logic         o_busy
`ifdef CMUL_SAT_EN
    ,
    output logic         o_sat
`endif
);

    if (MUL_LAT < 1 || MUL_LAT > 4 || Q >= N) begin : g_param_check
        $error("cmul_scheduler: MUL_LAT must be 1..4 and Q < N");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ADD, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [N-1:0]       ar_q, ai_q, br_q, bi_q;
    logic [N-1:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               load_ops, out_load;
    logic               issue_vld;
    logic [1:0]         issue_k;
    logic [MUL_LAT:0]   tag_vld_q;
    logic [MUL_LAT:0][1:0] tag_k_q;
    logic [N-1:0]       pp0_q, pp1_q, pp2_q, pp3_q;
    logic [N-1:0]       re_q, im_q, re_res, im_res;
    logic               valid_q, valid_d;
    logic               sat_q, sat_res;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Input side: o_ready is high only in IDLE. Output side: o_valid/o_re/o_im hold until i_ready.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        mul_a_d   = '0;
        mul_b_d   = '0;
        load_ops  = 1'b0;
        out_load  = 1'b0;
        valid_d   = valid_q;
        issue_vld = 1'b0;
        issue_k   = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    load_ops  = 1'b1;
                    mul_a_d   = i_ar;
                    mul_b_d   = i_br;
                    issue_vld = 1'b1;
                    issue_k   = 2'd0;
                    k_d       = 2'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // k_q names the pair on the multiplier now; load the next one.
                k_d       = k_q + 2'd1;
                issue_vld = (k_q != 2'd3);
                issue_k   = k_q + 2'd1;
                case (k_q)
                    2'd0:    begin mul_a_d = ai_q; mul_b_d = bi_q; end
                    2'd1:    begin mul_a_d = ar_q; mul_b_d = bi_q; end
                    2'd2:    begin mul_a_d = ai_q; mul_b_d = br_q; end
                    default: state_d = S_DRAIN;
                endcase
            end
            S_DRAIN: begin
                if (tag_vld_q[MUL_LAT] && tag_k_q[MUL_LAT] == 2'd3) state_d = S_ADD;
            end
            S_ADD: begin
                out_load = 1'b1;
                valid_d  = 1'b1;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CMUL_SAT_EN
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
    logic signed [N:0] re_sum, im_sum;
    always_comb begin
        re_sum  = $signed({pp0_q[N-1], pp0_q}) - $signed({pp1_q[N-1], pp1_q});
        im_sum  = $signed({pp2_q[N-1], pp2_q}) + $signed({pp3_q[N-1], pp3_q});
        re_res  = re_sum[N-1:0];
        im_res  = im_sum[N-1:0];
        sat_res = 1'b0;
        if (re_sum[N] != re_sum[N-1]) begin
            re_res  = re_sum[N] ? SAT_MIN : SAT_MAX;
            sat_res = 1'b1;
        end
        if (im_sum[N] != im_sum[N-1]) begin
            im_res  = im_sum[N] ? SAT_MIN : SAT_MAX;
            sat_res = 1'b1;
        end
    end
`else
    // N-bit arithmetic yields exactly the low N bits of the N+1-bit sum.
    always_comb begin
        re_res  = pp0_q - pp1_q;
        im_res  = pp2_q + pp3_q;
        sat_res = 1'b0;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
            tag_k_q   <= '0;
            pp0_q     <= '0;
            pp1_q     <= '0;
            pp2_q     <= '0;
            pp3_q     <= '0;
            re_q      <= '0;
            im_q      <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            valid_q <= valid_d;
            if (load_ops) begin
                ar_q <= i_ar;
                ai_q <= i_ai;
                br_q <= i_br;
                bi_q <= i_bi;
            end
            // Tag at stage MUL_LAT marks the cycle its product sits on i_mul_p.
            tag_vld_q <= {tag_vld_q[MUL_LAT-1:0], issue_vld};
            tag_k_q   <= {tag_k_q[MUL_LAT-1:0], issue_k};
            if (tag_vld_q[MUL_LAT]) begin
                case (tag_k_q[MUL_LAT])
                    2'd0:    pp0_q <= i_mul_p;
                    2'd1:    pp1_q <= i_mul_p;
                    2'd2:    pp2_q <= i_mul_p;
                    default: pp3_q <= i_mul_p;
                endcase
            end
            if (out_load) begin
                re_q  <= re_res;
                im_q  <= im_res;
                sat_q <= sat_res;
            end
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_mul_a = mul_a_q;
    assign o_mul_b = mul_b_q;
    assign o_valid = valid_q;
    assign o_re    = re_q;
    assign o_im    = im_q;
`ifdef CMUL_SAT_EN
    assign o_sat   = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule
